spi_byte_shifter: RTL and testbench

//  Byte-level SPI mode-0 shift engine (CPOL=0, CPHA=0) under the Wishbone SPI master controller.
//  The controller FSM requests one byte per transfer, drives chip-enable itself and sequences

---
 rtl/spi_byte_shifter.sv | 215 +++++++++++++++++++++
 tb/tb_spi_byte_shifter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_byte_shifter.sv
// -----------------------------------------------------------------------------
// spi_byte_shifter
//
// Purpose:
//    Byte-level SPI mode-0 shift engine (CPOL=0, CPHA=0). A controller asks for
//    one transfer at a time with a start pulse. This block generates SCK,
//    shifts MOSI out and samples MISO in, then pulses done with the received
//    word on rx_byte. Chip-enable is handled by the controller, not here.
//
// Parameters:
//    DIV_W   width of clk_div; each SCK half period lasts clk_div+1 clk cycles
//    DATA_W  bits per transfer (must be 2 or more)
//
// Ports:
//    clk      in   system clock, every register updates on its rising edge
//    reset    in   synchronous, active-high reset
//    start    in   transfer request, looked at only while busy=0
//    tx_byte  in   word to send, captured when start is accepted
//    clk_div  in   half-period divider, captured when start is accepted
//    busy     out  high from the cycle after an accepted start until done
//    done     out  one-cycle pulse; rx_byte is valid from this cycle on
//    rx_byte  out  last received word, held until the next done
//    sck      out  SPI clock, idles low
//    mosi     out  SPI data out, idles low
//    miso     in   SPI data in
//
// Build option:
//    SPI_LSB_FIRST_EN  when defined, tx_byte[0] goes out first and the first
//                      received bit lands in rx_byte[0]. When undefined, both
//                      lines are MSB first.
// -----------------------------------------------------------------------------
module spi_byte_shifter #(
   parameter int DIV_W  = 8,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [DATA_W-1:0] tx_byte,
   input  logic [DIV_W-1:0]  clk_div,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] rx_byte,
   output logic              sck,
   output logic              mosi,
   input  logic              miso
);

   localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOW,
      ST_HIGH
   } state_t;

   state_t            r_state;
   logic [DIV_W-1:0]  r_div;
   logic [DIV_W-1:0]  r_div_cnt;
   logic [BIT_W-1:0]  r_bit_cnt;
   logic [DATA_W-1:0] r_tx_shift;
   logic [DATA_W-1:0] r_rx_shift;
   logic [DATA_W-1:0] r_rx_byte;
   logic              r_busy;
   logic              r_done;
   logic              r_sck;
   logic              r_mosi;

   state_t            w_state_next;
   logic [DIV_W-1:0]  w_div_next;
   logic [DIV_W-1:0]  w_div_cnt_next;
   logic [BIT_W-1:0]  w_bit_cnt_next;
   logic [DATA_W-1:0] w_tx_shift_next;
   logic [DATA_W-1:0] w_rx_shift_next;
   logic [DATA_W-1:0] w_rx_byte_next;
   logic              w_busy_next;
   logic              w_done_next;
   logic              w_sck_next;
   logic              w_mosi_next;

   // Bit-order dependent views of the shift registers. r_tx_shift always holds
   // the bits still to be sent, lined up so the next one sits at the exit end.
   logic              w_first_bit;
   logic [DATA_W-1:0] w_tx_loaded;
   logic              w_next_bit;
   logic [DATA_W-1:0] w_tx_shifted;
   logic [DATA_W-1:0] w_rx_shifted;

`ifdef SPI_LSB_FIRST_EN
   assign w_first_bit  = tx_byte[0];
   assign w_tx_loaded  = tx_byte >> 1;
   assign w_next_bit   = r_tx_shift[0];
   assign w_tx_shifted = r_tx_shift >> 1;
   // New bits enter at the top, so after DATA_W samples the first one is bit 0.
   assign w_rx_shifted = {miso, r_rx_shift[DATA_W-1:1]};
`else
   assign w_first_bit  = tx_byte[DATA_W-1];
   assign w_tx_loaded  = tx_byte << 1;
   assign w_next_bit   = r_tx_shift[DATA_W-1];
   assign w_tx_shifted = r_tx_shift << 1;
   assign w_rx_shifted = {r_rx_shift[DATA_W-2:0], miso};
`endif

   // The half period is clk_div+1 cycles, so it ends when the counter reaches
   // the captured divider itself; this avoids a wider H = clk_div+1 adder.
   logic w_phase_end;
   logic w_last_bit;
   assign w_phase_end = (r_div_cnt == r_div);
   assign w_last_bit  = (r_bit_cnt == BIT_W'(DATA_W - 1));

   always_comb begin
      w_state_next    = r_state;
      w_div_next      = r_div;
      w_div_cnt_next  = r_div_cnt;
      w_bit_cnt_next  = r_bit_cnt;
      w_tx_shift_next = r_tx_shift;
      w_rx_shift_next = r_rx_shift;
      w_rx_byte_next  = r_rx_byte;
      w_busy_next     = r_busy;
      w_done_next     = 1'b0;
      w_sck_next      = r_sck;
      w_mosi_next     = r_mosi;

      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_div_next      = clk_div;
               w_tx_shift_next = w_tx_loaded;
               w_mosi_next     = w_first_bit;
               w_sck_next      = 1'b0;
               w_busy_next     = 1'b1;
               w_div_cnt_next  = '0;
               w_bit_cnt_next  = '0;
               w_state_next    = ST_LOW;
            end
         end

         ST_LOW: begin
            if (w_phase_end) begin
               // Rising SCK edge: MISO is sampled on this same clk edge.
               w_sck_next      = 1'b1;
               w_rx_shift_next = w_rx_shifted;
               w_div_cnt_next  = '0;
               w_state_next    = ST_HIGH;
            end else begin
               w_div_cnt_next  = r_div_cnt + DIV_W'(1);
            end
         end

         ST_HIGH: begin
            if (w_phase_end) begin
               w_sck_next     = 1'b0;
               w_div_cnt_next = '0;
               if (w_last_bit) begin
                  w_busy_next    = 1'b0;
                  w_done_next    = 1'b1;
                  w_rx_byte_next = r_rx_shift;
                  w_mosi_next    = 1'b0;
                  w_state_next   = ST_IDLE;
               end else begin
                  // Falling SCK edge: present the next MOSI bit.
                  w_bit_cnt_next  = r_bit_cnt + BIT_W'(1);
                  w_mosi_next     = w_next_bit;
                  w_tx_shift_next = w_tx_shifted;
                  w_state_next    = ST_LOW;
               end
            end else begin
               w_div_cnt_next = r_div_cnt + DIV_W'(1);
            end
         end

         default: begin
            w_state_next = ST_IDLE;
            w_busy_next  = 1'b0;
            w_sck_next   = 1'b0;
            w_mosi_next  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= ST_IDLE;
         r_div      <= '0;
         r_div_cnt  <= '0;
         r_bit_cnt  <= '0;
         r_tx_shift <= '0;
         r_rx_shift <= '0;
         r_rx_byte  <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_sck      <= 1'b0;
         r_mosi     <= 1'b0;
      end else begin
         r_state    <= w_state_next;
         r_div      <= w_div_next;
         r_div_cnt  <= w_div_cnt_next;
         r_bit_cnt  <= w_bit_cnt_next;
         r_tx_shift <= w_tx_shift_next;
         r_rx_shift <= w_rx_shift_next;
         r_rx_byte  <= w_rx_byte_next;
         r_busy     <= w_busy_next;
         r_done     <= w_done_next;
         r_sck      <= w_sck_next;
         r_mosi     <= w_mosi_next;
      end
   end

   assign busy    = r_busy;
   assign done    = r_done;
   assign rx_byte = r_rx_byte;
   assign sck     = r_sck;
   assign mosi    = r_mosi;

endmodule

// File: tb/tb_spi_byte_shifter.sv
// -----------------------------------------------------------------------------
// tb_spi_byte_shifter
//
// Purpose:
//    Self-checking bench for spi_byte_shifter (DIV_W=8, DATA_W=8). Directed
//    transfers plus randomized ones are compared against expectations worked
//    out from the transfer rules: done after 16*(clk_div+1) cycles, 8 SCK
//    pulses of clk_div+1 cycles each, MOSI carrying tx_byte in wire order and
//    rx_byte equal to the word presented on MISO.
//
// Build option:
//    SPI_LSB_FIRST_EN  selects LSB-first wire order, matching the design.
// -----------------------------------------------------------------------------
module tb_spi_byte_shifter;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic [7:0] tx_byte;
   logic [7:0] clk_div;
   logic       busy;
   logic       done;
   logic [7:0] rx_byte;
   logic       sck;
   logic       mosi;
   logic       miso;

   // MISO either loops back MOSI or follows a bench-driven pattern.
   logic       use_loop;
   logic       miso_drv;
   assign miso = use_loop ? mosi : miso_drv;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   spi_byte_shifter #(.DIV_W(8), .DATA_W(8)) dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .tx_byte (tx_byte),
      .clk_div (clk_div),
      .busy    (busy),
      .done    (done),
      .rx_byte (rx_byte),
      .sck     (sck),
      .mosi    (mosi),
      .miso    (miso)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
   endtask

   // k-th bit on the wire (k=0 goes first) for a given word.
   function automatic logic wire_bit(input logic [7:0] w, input int k);
`ifdef SPI_LSB_FIRST_EN
      return w[k];
`else
      return w[7-k];
`endif
   endfunction

   // One complete transfer. Inputs are driven and outputs sampled on the
   // falling clock edge. n counts rising edges since the accepting edge.
   task automatic xfer(input string name, input logic [7:0] tx, input logic [7:0] div,
                       input logic loop, input logic [7:0] pat, input bit poke);
      int         h;
      int         exp_n;
      int         n;
      int         rises;
      int         falls;
      int         hi_len;
      int         done_n;
      int         done_cnt;
      int         bad_width;
      int         mosi_bad;
      int         overlap;
      logic       prev_sck;
      logic [7:0] exp_rx;

      h         = int'(div) + 1;
      exp_n     = 16 * h;
      exp_rx    = loop ? tx : pat;
      rises     = 0;
      falls     = 0;
      hi_len    = 0;
      done_n    = -1;
      done_cnt  = 0;
      bad_width = 0;
      mosi_bad  = 0;
      overlap   = 0;
      use_loop  = loop;
      miso_drv  = wire_bit(pat, 0);

      @(negedge clk);
      start   = 1'b1;
      tx_byte = tx;
      clk_div = div;
      @(negedge clk);
      start   = 1'b0;
      // Changing these mid-transfer must not matter.
      tx_byte = ~tx;
      clk_div = ~div;
      check({name, "_busy_after_start"}, 32'(busy), 32'd1);

      n        = 0;
      prev_sck = sck;
      while (n < exp_n + 2 * h + 4) begin
         @(negedge clk);
         n++;
         start = poke && (n == 5 || n == 10);
         if (done) begin
            done_cnt++;
            if (done_n < 0) done_n = n;
         end
         if (busy && done) overlap++;
         if (!prev_sck && sck) begin
            if (rises < 8 && mosi !== wire_bit(tx, rises)) mosi_bad++;
            rises++;
            hi_len = 1;
         end else if (prev_sck && sck) begin
            hi_len++;
         end else if (prev_sck && !sck) begin
            if (hi_len != h) bad_width++;
            falls++;
            if (falls < 8) miso_drv = wire_bit(pat, falls);
         end
         prev_sck = sck;
      end
      start = 1'b0;

      check({name, "_done_cycle"}, 32'(done_n), 32'(exp_n));
      check({name, "_done_count"}, 32'(done_cnt), 32'd1);
      check({name, "_rx_byte"}, 32'(rx_byte), 32'(exp_rx));
      check({name, "_sck_pulses"}, 32'(rises), 32'd8);
      check({name, "_sck_high_width_errs"}, 32'(bad_width), 32'd0);
      check({name, "_mosi_bit_errs"}, 32'(mosi_bad), 32'd0);
      check({name, "_busy_done_overlap"}, 32'(overlap), 32'd0);
      check({name, "_idle_lines"}, {30'd0, sck, mosi}, 32'd0);
      $display("xfer %s tx=%02h div=%0d loop=%0d pat=%02h -> rx=%02h done_at=%0d pulses=%0d",
               name, tx, div, loop, pat, rx_byte, done_n, rises);
   endtask

   initial begin
      int         d1;
      int         d2;
      int         bad;
      logic [7:0] r1;
      logic [7:0] r2;

      reset    = 1'b1;
      start    = 1'b0;
      tx_byte  = 8'h00;
      clk_div  = 8'h00;
      use_loop = 1'b0;
      miso_drv = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_done", 32'(done), 32'd0);
      check("reset_rx_byte", 32'(rx_byte), 32'd0);
      check("reset_sck", 32'(sck), 32'd0);
      check("reset_mosi", 32'(mosi), 32'd0);
      reset = 1'b0;
      $display("reset released: busy=%0d done=%0d rx=%02h", busy, done, rx_byte);

      // Reset at cycle 20 of a clk_div=3 transfer aborts it.
      use_loop = 1'b1;
      @(negedge clk);
      start   = 1'b1;
      tx_byte = 8'hF0;
      clk_div = 8'd3;
      @(negedge clk);
      start = 1'b0;
      repeat (20) @(negedge clk);
      check("abort_was_busy", 32'(busy), 32'd1);
      reset = 1'b1;
      @(negedge clk);
      check("abort_sck", 32'(sck), 32'd0);
      check("abort_mosi", 32'(mosi), 32'd0);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_rx_byte", 32'(rx_byte), 32'd0);
      reset = 1'b0;
      bad = 0;
      for (int i = 0; i < 80; i++) begin
         @(negedge clk);
         if (done || busy || sck) bad++;
      end
      check("abort_no_done_after", 32'(bad), 32'd0);
      $display("abort: reset at cycle 20, activity after=%0d rx=%02h", bad, rx_byte);

      // Directed transfers.
      xfer("div0_loop_a5", 8'hA5, 8'd0, 1'b1, 8'h00, 1'b0);
      xfer("div3_pat_c3", 8'h3C, 8'd3, 1'b0, 8'hC3, 1'b0);
      xfer("ignored_start", 8'h5A, 8'd0, 1'b1, 8'h00, 1'b1);
      xfer("single_bit_01", 8'h01, 8'd0, 1'b1, 8'h00, 1'b0);
      xfer("div255_pat", 8'h96, 8'd255, 1'b0, 8'h69, 1'b0);

      // Start held high through done: the second transfer is accepted on the
      // edge that ends the first done cycle and finishes 16 cycles later.
      use_loop = 1'b1;
      @(negedge clk);
      start   = 1'b1;
      tx_byte = 8'h01;
      clk_div = 8'd0;
      @(negedge clk);
      tx_byte = 8'h80;
      d1  = -1;
      d2  = -1;
      r1  = 8'h00;
      r2  = 8'h00;
      bad = 0;
      for (int i = 1; i <= 50; i++) begin
         @(negedge clk);
         if (d2 < 0 && busy === done) bad++;
         if (done) begin
            if (d1 < 0) begin
               d1 = i;
               r1 = rx_byte;
            end else if (d2 < 0) begin
               d2 = i;
               r2 = rx_byte;
            end
         end
         if (d1 > 0 && i == d1 + 1) start = 1'b0;
      end
      start = 1'b0;
      check("b2b_first_done", 32'(d1), 32'd16);
      check("b2b_first_rx", 32'(r1), 32'h01);
      check("b2b_second_done", 32'(d2), 32'(d1 + 17));
      check("b2b_second_rx", 32'(r2), 32'h80);
      check("b2b_busy_gap_errs", 32'(bad), 32'd0);
      $display("b2b: done1=%0d rx1=%02h done2=%0d rx2=%02h gap_errs=%0d", d1, r1, d2, r2, bad);

      // Randomized transfers.
      for (int t = 0; t < 8; t++) begin
         logic [7:0] rtx;
         logic [7:0] rdiv;
         logic [7:0] rpat;
         logic       rloop;
         rtx   = 8'($urandom);
         rdiv  = 8'($urandom_range(0, 5));
         rpat  = 8'($urandom);
         rloop = 1'($urandom_range(0, 1));
         xfer("rand", rtx, rdiv, rloop, rpat, t[0]);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
